// File: rtl/fixed_mul_seq.sv
// fixed_mul_seq: sequential radix-2 shift-add multiplier for denormalized
// 64-bit unsigned fractions (binary point above the MSB, values in [0,1)).
// The result is the upper W bits of the 2W-bit product, so it stays in [0,1).
//
// One operand pair is in flight at a time. It is accepted in IDLE. BUSY runs
// one shift-add iteration per cycle for W cycles. DONE holds the product
// until the consumer takes it.
//
// Optional build macro:
//   FXMUL_ROUND_EN - when defined, round half-up using the MSB of the
//                    discarded lower half. Otherwise the result is truncated.
module fixed_mul_seq #(
    parameter int W  = 64,
    parameter int CW = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] u1,
    input  logic [W-1:0] u2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] prod,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value during the final iteration; the edge that completes it
    // moves the machine to DONE.
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [W-1:0]  a_reg;      // latched multiplicand
    logic [W-1:0]  a_nxt;
    logic [W:0]    p_hi;       // upper partial product, one extra carry bit
    logic [W:0]    p_hi_nxt;
    logic [W-1:0]  p_lo;       // multiplier bits, gradually replaced by low product bits
    logic [W-1:0]  p_lo_nxt;
    logic [W:0]    sum;        // conditional add of the multiplicand
    logic [W-1:0]  prod_val;   // product as presented in DONE

    // Conditional add for the current iteration. The carry lands in bit W
    // and is absorbed by the following right shift.
    always_comb begin
        sum = {(W+1){1'b0}};
        if (p_lo[0]) begin
            sum = p_hi + {1'b0, a_reg};
        end else begin
            sum = p_hi;
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        a_nxt     = a_reg;
        p_hi_nxt  = p_hi;
        p_lo_nxt  = p_lo;
        case (state)
            IDLE: begin
                // Only accept when in_ready is asserted. This keeps the
                // handshake honest in the first cycle after reset.
                if (in_valid && in_ready) begin
                    a_nxt     = u1;
                    p_lo_nxt  = u2;
                    p_hi_nxt  = {(W+1){1'b0}};
                    count_nxt = {CW{1'b0}};
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                // {p_hi, p_lo} = {sum, p_lo} >> 1 with zero fill.
                p_hi_nxt  = {1'b0, sum[W:1]};
                p_lo_nxt  = {sum[0], p_lo[W-1:1]};
                count_nxt = count + CNT_ONE;
                if (count == LAST_ITER) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= {CW{1'b0}};
            a_reg <= {W{1'b0}};
            p_hi  <= {(W+1){1'b0}};
            p_lo  <= {W{1'b0}};
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            a_reg <= a_nxt;
            p_hi  <= p_hi_nxt;
            p_lo  <= p_lo_nxt;
        end
    end

    // Handshake and status flags, registered from the next state so they
    // stay aligned with the state register. Reset clears them, so in_ready
    // first rises on the edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == BUSY);
        end
    end

`ifdef FXMUL_ROUND_EN
    // Round half-up on the discarded lower half. The upper half never
    // exceeds 2^W-2, so the increment cannot overflow.
    always_comb begin
        prod_val = p_hi[W-1:0] + {{(W-1){1'b0}}, p_lo[W-1]};
    end
`else
    // Truncation: the upper half of the product is the result.
    always_comb begin
        prod_val = p_hi[W-1:0];
    end
`endif

    // Present the product only while it is valid. Otherwise drive zero.
    // The source registers do not change in DONE, so prod is stable
    // during a stall.
    always_comb begin
        prod = {W{1'b0}};
        if (out_valid) begin
            prod = prod_val;
        end else begin
            prod = {W{1'b0}};
        end
    end

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Self-checking bench for fixed_mul_seq: table-driven directed vectors,
// randomized operands against an arithmetic reference, plus sequences
// for back-to-back acceptance, backpressure and mid-operation reset.
module tb_fixed_mul_seq;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] u1;
    logic [W-1:0] u2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] prod;
    logic         busy;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           stall;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [5];

    fixed_mul_seq #(.W(64), .CW(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .u1        (u1),
        .u2        (u2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: upper half of the full 128-bit product, with
    // half-up rounding when the build enables it.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] full;
        logic [W-1:0]   r;
        full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r    = full[2*W-1:W];
`ifdef FXMUL_ROUND_EN
        r    = r + {{(W-1){1'b0}}, full[W-1]};
`endif
        return r;
    endfunction

    task automatic chk64(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wait (bounded) at negedges until in_ready is seen.
    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk1("ready_timeout", in_ready, 1'b1);
    endtask

    // One complete transaction: accept, measure latency, stall, hand off.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input logic [W-1:0] exp, input string nm);
        int           k;
        logic [W-1:0] held;
        wait_ready();
        in_valid  = 1'b1;
        u1        = a;
        u2        = b;
        out_ready = (stall == 0);
        @(posedge clk);            // acceptance edge
        #1 in_valid = 1'b0;
        u1 = ~a;                   // must not disturb the latched operands
        u2 = ~b;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 10) chk1({nm, "_busy_mid"}, busy, 1'b1);
        end while (!out_valid && k < 200);
        chkint({nm, "_latency"}, k, 64);
        chk64({nm, "_prod"}, prod, exp);
        chk1({nm, "_busy_done"}, busy, 1'b0);
        chk1({nm, "_in_ready_done"}, in_ready, 1'b0);
        held = prod;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;       // ignored outside IDLE
            @(posedge clk);
            @(negedge clk);
            chk1({nm, "_stall_valid"}, out_valid, 1'b1);
            chk64({nm, "_stall_prod"}, prod, held);
            chk1({nm, "_stall_in_ready"}, in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);            // handshake edge
        @(negedge clk);
        chk1({nm, "_valid_drop"}, out_valid, 1'b0);
        chk1({nm, "_in_ready_after"}, in_ready, 1'b1);
        out_ready = 1'b1;          // high outside DONE: must be ignored
    endtask

    initial begin
        int           t;
        int           acc1;
        int           acc2;
        int           k;
        int           nvalid;
        logic         will_acc;
        logic [W-1:0] got1;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        u1        = 64'h0;
        u2        = 64'h0;

        tbl[0] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 64'h4000_0000_0000_0000};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFE};
`ifdef FXMUL_ROUND_EN
        tbl[2] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 0, 64'h4000_0000_0000_0001};
`else
        tbl[2] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 0, 64'h4000_0000_0000_0000};
`endif
        tbl[3] = '{64'h0000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, 0, 64'h0000_0000_0000_0000};
        tbl[4] = '{64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000, 20, 64'h9000_0000_0000_0000};

        // Reset values while rst is asserted.
        #1 rst = 1'b1;
        #12;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk64("rst_prod", prod, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1("in_ready_after_rst", in_ready, 1'b1);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back: in_valid held high and the second pair presented
        // right after the first acceptance.
        a2 = 64'hA5A5_0000_FFFF_1234;
        b2 = 64'h7FFF_FFFF_8000_0001;
        wait_ready();
        in_valid  = 1'b1;
        u1        = 64'h0;
        u2        = 64'h1234_5678_9ABC_DEF0;
        out_ready = 1'b1;
        t = 0; acc1 = -1; acc2 = -1; nvalid = 0; got1 = 64'h0;
        while (acc2 < 0 && t < 300) begin
            will_acc = in_ready;
            @(posedge clk);
            t++;
            if (will_acc) begin
                if (acc1 < 0) begin
                    acc1 = t;
                    #1 u1 = a2;
                    u2 = b2;
                end else begin
                    acc2 = t;
                    #1 in_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (out_valid && nvalid == 0) begin
                got1   = prod;
                nvalid = 1;
            end
        end
        in_valid = 1'b0;
        chkint("b2b_first_seen", nvalid, 1);
        chk64("b2b_first_prod", got1, 64'h0);
        chkint("b2b_gap", acc2 - acc1, 66);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk64("b2b_second_prod", prod, model(a2, b2));
        @(negedge clk);
        chk1("b2b_second_drop", out_valid, 1'b0);

        // Randomized operands against the reference model.
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 0) ra[W-1:0] = {1'b1, ra[W-2:0]};
            run_op(ra, rb, $urandom_range(0, 3), model(ra, rb), $sformatf("rnd%0d", i));
        end

        // Reset at iteration 30 aborts the operation.
        wait_ready();
        in_valid  = 1'b1;
        u1        = 64'hFFFF_FFFF_FFFF_FFFF;
        u2        = 64'hFFFF_FFFF_FFFF_FFFF;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b0);
        chk64("abort_prod", prod, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1("abort_in_ready_after", in_ready, 1'b1);
        nvalid = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        chkint("abort_no_output", nvalid, 0);
        run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0,
               model(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000), "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_mul_seq.md
Name: fixed_mul_seq

Overview:
- Sequential radix-2 shift-add multiplier. Consumes the pair of denormalized 64-bit unsigned fractions produced by the denormalization stage (binary point above bit 63, values in [0,1)).
- Returns the 64-bit fraction product, i.e. the upper half of the 128-bit product, still in [0,1) format.
- Sits directly downstream of denormalization, ahead of renormalization back to IEEE-754.
- valid/ready on both sides; one operation in flight.

Parameters:
- W, 64, operand and result width in bits; iteration count equals W.
- CW, 7, counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- u1  input  W  multiplicand fraction (Denorm_u1)
- u2  input  W  multiplier fraction (Denorm_u2)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- prod  output  W  upper W bits of u1*u2 (rounded if feature enabled)
- busy  output  1  high in BUSY state

Behaviour:
- Reset: asynchronous, active-high.
  - state=IDLE, count=0, accumulator and operand registers cleared.
  - Outputs during reset: in_ready=0, out_valid=0, prod=0, busy=0.
  - in_ready goes high the first cycle after rst deasserts.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch A=u1, P_lo=u2, P_hi=0 (W+1 bits), count=0, and go to BUSY.
  - Inputs are ignored when in_valid=0.
- BUSY (one iteration per cycle):
  - in_ready=0.
  - Each iteration: sum = P_hi + (P_lo[0] ? A : 0) in W+1 bits; then {P_hi,P_lo} = {sum,P_lo} >> 1, zero-filled.
  - count increments. The edge that completes iteration W-1 moves to DONE.
- DONE:
  - out_valid=1; prod = P_hi[W-1:0] (truncated), or the rounded value when the optional feature is enabled.
  - prod holds stable while out_valid=1 and out_ready=0 (no limit on stall length).
  - On an edge with out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency: out_valid is high in the cycle after the W-th edge following the acceptance edge, i.e. W cycles after acceptance (64 by default).
- Throughput: one product per W+2 cycles minimum.
  - No accept in the same cycle as out_valid handshake, because in_ready=0 in DONE.
- in_valid held high in BUSY/DONE: ignored, no second capture. Upstream holds u1/u2 until in_ready.
- out_ready high outside DONE: ignored.
- Reset mid-operation: aborts immediately to the reset values above; the partial product is discarded and no out_valid is produced.
- Arithmetic: P_hi carry bit (bit W) is consumed by the shift. The final upper product is at most 2^W-2, so no overflow is possible.

Optional Feature:
- Macro FXMUL_ROUND_EN.
- Defined: in DONE, prod = P_hi[W-1:0] + P_lo[W-1] (round half-up on the discarded half).
  - Cannot overflow, since the maximum upper half is 2^W-2.
  - Adder is computed combinationally from registered values; latency unchanged.
- Undefined: prod = P_hi[W-1:0] (truncation); no rounding logic is instantiated.

Test Plan:
- u1=u2=0x8000_0000_0000_0000, out_ready=1 -> prod=0x4000_0000_0000_0000; out_valid exactly 64 cycles after acceptance, high for 1 cycle.
- u1=u2=0xFFFF_FFFF_FFFF_FFFF -> prod=0xFFFF_FFFF_FFFF_FFFE in both macro settings (discarded bit 63 is 0).
- u1=0x8000_0000_0000_0001, u2=0x8000_0000_0000_0000 -> prod=0x4000_0000_0000_0000 without FXMUL_ROUND_EN, 0x4000_0000_0000_0001 with it.
- u1=0, u2=0x1234_5678_9ABC_DEF0 -> prod=0. Then back-to-back in_valid held high -> second pair is accepted only after IDLE re-entry; gap between acceptances is at least 66 cycles.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and prod stay stable and in_ready stays 0; on out_ready=1, IDLE is reached and in_ready=1 the next cycle.
- Assert rst at iteration 30 -> within the same cycle busy=0 and out_valid=0; after release in_ready=1; a new operation 0.5*0.5 completes with the correct result.
